// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, program-entry
// layout and FSM state encoding.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int ENTRY_W  = 6;
  localparam int CTRL_LSB = 4;
  localparam int A_LSB    = 2;
  localparam int B_LSB    = 0;

  typedef struct packed {
    logic [1:0] ctrl;
    logic [1:0] a;
    logic [1:0] b;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_OUTPUT,
    ST_DONE
  } state_t;

  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] w);
    entry_t e;
    e.ctrl = w[CTRL_LSB +: 2];
    e.a    = w[A_LSB +: 2];
    e.b    = w[B_LSB +: 2];
    return e;
  endfunction

endpackage

// File: rtl/alu_prog_mem.sv
// Program store: DEPTH x W register file, one synchronous write port and
// one asynchronous read port. Contents survive reset.
module alu_prog_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues a stored program of {ctrl, A, B} ops to an external combinational
// ALU one at a time and streams each captured {c, y} out on valid/ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int ERRW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [5:0]      wr_data,
  input  logic            start,
  input  logic [AW:0]     len,
  output logic [1:0]      alu_a,
  output logic [1:0]      alu_b,
  output logic [1:0]      alu_ctrl,
  input  logic [3:0]      alu_y,
  input  logic            alu_c,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [3:0]      res_data,
  output logic            res_carry,
  output logic [AW-1:0]   res_idx,
  output logic            busy,
  output logic            done,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t          r_state, w_next;
  logic [AW:0]     r_cnt_max;
  logic [AW-1:0]   r_idx;
  logic [1:0]      r_alu_a, r_alu_b, r_alu_ctrl;
  logic            r_res_valid;
  logic [3:0]      r_res_data;
  logic            r_res_carry;
  logic [AW-1:0]   r_res_idx;
  logic [ERRW-1:0] r_err_cnt;

  logic [AW:0]     w_len_clamp;
  logic [AW:0]     w_idx_inc;
  logic            w_hs;
  logic            w_mem_we;
  logic [5:0]      w_rd_data;
  entry_t          w_entry;

  assign w_len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign w_idx_inc   = {1'b0, r_idx} + (AW+1)'(1);
  assign w_hs        = (r_state == ST_OUTPUT) && r_res_valid && res_ready;
  // Program edits are only safe while nothing is being executed.
  assign w_mem_we    = wr_en && (r_state == ST_IDLE);
  assign w_entry     = unpack_entry(w_rd_data);

  alu_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_mem_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (r_idx),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = (w_len_clamp == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_OUTPUT;
      ST_OUTPUT:  if (w_hs) w_next = (w_idx_inc == r_cnt_max) ? ST_DONE : ST_ISSUE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_max   <= '0;
      r_idx       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_idx   <= '0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt_max <= w_len_clamp;
            r_idx     <= '0;
          end
        end
        ST_ISSUE: begin
          r_alu_ctrl <= w_entry.ctrl;
          r_alu_a    <= w_entry.a;
          r_alu_b    <= w_entry.b;
        end
        ST_CAPTURE: begin
          r_res_data  <= alu_y;
          r_res_carry <= alu_c;
          r_res_idx   <= r_idx;
          r_res_valid <= 1'b1;
          // Divide-by-zero tally sticks at all-ones rather than wrapping.
          if ((r_alu_ctrl == OP_DIV) && alu_c && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + ERRW'(1);
        end
        ST_OUTPUT: begin
          if (w_hs) begin
            r_res_valid <= 1'b0;
            r_idx       <= r_idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_ctrl  = r_alu_ctrl;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_idx   = r_res_idx;
  assign err_cnt   = r_err_cnt;
  assign busy      = (r_state == ST_ISSUE) || (r_state == ST_CAPTURE) ||
                     (r_state == ST_OUTPUT);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 2-bit ALU attached.
module tb_alu_op_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int ERRW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [5:0]      wr_data;
  logic            start;
  logic [AW:0]     len;
  logic [1:0]      alu_a, alu_b, alu_ctrl;
  logic [3:0]      alu_y;
  logic            alu_c;
  logic            res_valid;
  logic            res_ready;
  logic [3:0]      res_data;
  logic            res_carry;
  logic [AW-1:0]   res_idx;
  logic            busy;
  logic            done;
  logic [ERRW-1:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int ndone = 0;
  int nres  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH), .AW(AW), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_c(alu_c), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_idx(res_idx),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  // Behavioural ALU: 4-bit result, c = borrow on sub, divide-by-zero on div.
  always_comb begin
    alu_y = 4'h0;
    alu_c = 1'b0;
    case (alu_ctrl)
      2'b00: alu_y = {2'b00, alu_a} + {2'b00, alu_b};
      2'b01: begin
        alu_y = {2'b00, alu_a} - {2'b00, alu_b};
        alu_c = (alu_a < alu_b);
      end
      2'b10: alu_y = {2'b00, alu_a} * {2'b00, alu_b};
      default: begin
        if (alu_b == 2'b00) alu_c = 1'b1;
        else                alu_y = {2'b00, alu_a / alu_b};
      end
    endcase
  end

  always @(posedge clk) begin
    if (done) ndone <= ndone + 1;
    if (res_valid && res_ready) nres <= nres + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [5:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr[AW-1:0]; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    @(negedge clk);
    start = 1'b1; len = n[AW:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (res_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic get_res(input string tag, input logic [3:0] d, input logic c, input logic [AW-1:0] i);
    bit ok;
    wait_valid(ok);
    chk({tag, "_vld"}, 32'(ok), 32'd1);
    if (ok) chk({tag, "_res"}, {res_data, 3'b0, res_carry, 5'b0, res_idx},
                {d, 3'b0, c, 5'b0, i});
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(ok), 32'd1);
    if (ok) chk({tag, "_busy0"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0;
    bit ok;
    logic [11:0] hold_exp;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outs", {res_valid, busy, done, res_carry, res_data, alu_ctrl, alu_a, alu_b},
        32'd0);
    chk("rst_idx_err", {res_idx, err_cnt}, 32'd0);
    rst = 1'b0;

    // single add 3+2
    wr(0, 6'b00_11_10);
    d0 = ndone;
    run(1);
    chk("add_busy", 32'(busy), 32'd1);
    get_res("add", 4'h5, 1'b0, 3'd0);
    chk("add_alu", {alu_ctrl, alu_a, alu_b}, {2'b00, 2'd3, 2'd2});
    wait_done("add");
    chk("add_ndone", ndone - d0, 32'd1);

    // sub / mul / div
    wr(0, 6'b01_01_10);
    wr(1, 6'b10_11_11);
    wr(2, 6'b11_11_10);
    d0 = ndone;
    run(3);
    get_res("sub", 4'hF, 1'b1, 3'd0);
    get_res("mul", 4'h9, 1'b0, 3'd1);
    get_res("div", 4'h1, 1'b0, 3'd2);
    wait_done("smd");
    chk("smd_ndone", ndone - d0, 32'd1);
    chk("smd_err", 32'(err_cnt), 32'd0);

    // divide by zero and saturation
    wr(0, 6'b11_11_00);
    wr(1, 6'b11_11_00);
    run(2);
    get_res("dz0", 4'h0, 1'b1, 3'd0);
    get_res("dz1", 4'h0, 1'b1, 3'd1);
    wait_done("dz");
    chk("dz_err2", 32'(err_cnt), 32'd2);
    repeat (6) begin run(2); wait_done("dzr"); end
    chk("dz_err14", 32'(err_cnt), 32'd14);
    run(2); wait_done("dzs");
    chk("dz_err15", 32'(err_cnt), 32'd15);
    run(2); wait_done("dzh");
    chk("dz_hold15", 32'(err_cnt), 32'd15);

    // backpressure
    wr(0, 6'b00_01_01);
    wr(1, 6'b10_10_11);
    res_ready = 1'b0;
    run(2);
    wait_valid(ok);
    chk("bp_vld", 32'(ok), 32'd1);
    hold_exp = {1'b1, 4'h2, 1'b0, 3'd0, 2'b00, 1'b1};
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", {res_valid, res_data, res_carry, res_idx, alu_ctrl, busy}, hold_exp);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop", 32'(res_valid), 32'd0);
    get_res("bp1", 4'h6, 1'b0, 3'd1);
    wait_done("bp");

    // len=0 and len clamp
    d0 = ndone; r0 = nres;
    run(0);
    chk("len0_done", {done, res_valid, busy}, 32'b100);
    @(negedge clk);
    @(negedge clk);
    chk("len0_cnt", {ndone - d0, nres - r0}, {32'd1, 32'd0});
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      wr(i, {2'b00, iv[1:0], 1'b0, iv[2]});
    end
    d0 = ndone; r0 = nres;
    run(9);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      get_res("clamp", {2'b00, iv[1:0]} + {3'b000, iv[2]}, 1'b0, iv);
    end
    wait_done("clamp");
    chk("clamp_cnt", {ndone - d0, nres - r0}, {32'd1, 32'd8});

    // write while busy dropped, reset mid-run
    res_ready = 1'b0;
    run(3);
    wait_valid(ok);
    chk("mid_vld", 32'(ok), 32'd1);
    wr_en = 1'b1; wr_addr = '0; wr_data = 6'b10_11_11;
    @(negedge clk);
    wr_en = 1'b0;
    d0 = ndone;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_outs", {res_valid, busy, done, res_carry, res_data, alu_ctrl, alu_a, alu_b},
        32'd0);
    chk("mid_rst_idx_err", {res_idx, err_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_nodone", ndone - d0, 32'd0);
    run(1);
    get_res("wrbusy", 4'h0, 1'b0, 3'd0);
    chk("wrbusy_alu", {alu_ctrl, alu_a, alu_b}, 32'd0);
    wait_done("wrbusy");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
